multi_pulse_generator: RTL and testbench
========================================

# multi_pulse_generator

Multi-channel, parametrised successor to the single-channel periodic pulse generator. Each of `CHANNELS` independent channels emits a one-cycle strobe every `ticks[i]` enabled clocks (periodic mode) or once, `ticks[i]` enabled clocks after a start request (one-shot mode). A global `sync` input phase-aligns all channels. Used as the shared strobe source for the display, debounce and UART-tick logic.

## Interface

- `N`, default 8: counter/period width; max period 2^N-1.
- `CHANNELS`, default 4: number of independent channels.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `ena`  in  CHANNELS: per-channel count enable; an edge with `ena[i]=1` is an "enabled edge" of channel i.
- `ticks`  in  CHANNELS*N: packed periods; channel i uses `ticks[i*N +: N]`.
- `mode`  in  CHANNELS: 0 = periodic, 1 = one-shot.
- `start`  in  CHANNELS: one-shot arm/restart request; ignored in periodic mode.
- `sync`  in  1: global phase-align; clears all counters.
- `out`  out  CHANNELS: registered one-cycle strobes.
- `busy`  out  CHANNELS: one-shot armed and counting.

## Operation

- Per channel: N-bit counter `cnt`, registered `out`, `busy`, and a registered copy `mode_q` of `mode`.
- Priority per edge: `rst` > `sync` > mode change > `start` > count.
- `rst`: `cnt`=0, `out`=0, `busy`=0, `mode_q`=`mode`.
- `sync`: all channels `cnt`=0, `out`=0, `busy`=0; `start` on the same edge is dropped.
- Mode change (`mode[i]`≠`mode_q[i]`): `cnt`=0, `out`=0, `busy`=0, `mode_q` updated.
- `out` defaults to 0 on every edge; it is set only by a terminal count.
- Terminal count: enabled edge with `cnt >= T-1`, where T = `ticks[i]`. The comparison is `>=`, not `==`, so lowering T mid-count never waits for an N-bit wrap.
- Periodic: on each enabled edge, terminal → `cnt`=0 and `out`=1; otherwise `cnt`+1. Not enabled → `cnt` holds.
- One-shot: `start[i]` → `cnt`=0, `busy`=1. `start` while busy restarts the count. While busy, count as in periodic mode; terminal → `out`=1, `busy`=0. Not busy → no counting, no pulses.
- T=0: channel inert. `cnt` held at 0, `out`=0, `start` ignored, `busy` cleared.
- T=1: `out` high after every enabled edge; a one-shot pulses after the first enabled edge following `start`.
- Counter arithmetic is N-bit unsigned; `cnt` never exceeds 2^N-2.

## Timing

- All outputs are registered. Reset values: `out`=0, `busy`=0.
- Periodic, `ena` held high from the first edge after `rst`: `out` is high after enabled edges T, 2T, 3T, … each time for exactly one cycle.
- `ena` low stretches the period by the number of disabled edges. A pulse never lasts more than one cycle.
- One-shot: `start` at edge k with `ena` continuously high → `busy` high from k+1, `out` high for the one cycle after edge k+T, and `busy` low from that same cycle.
- `ticks` changes take effect on the next edge.
- `rst` or `sync` mid-operation aborts any pending pulse.

## Configuration

- `MULTI_PULSE_GEN_PHASE_EN` defined:
  - Adds input `phase` (CHANNELS*N bits).
  - On `sync` each counter loads `phase[i*N +: N]` instead of 0.
  - A value ≥ T-1 makes the channel terminal on its next enabled edge.
  - `rst` still loads 0.
- Not defined: port `phase` is absent; `sync` loads 0.

## Test plan

- N=8, CHANNELS=4, ticks={3,5,1,0}, all periodic, `ena` high → `out[0]` every 3 cycles, `out[1]` every 5, `out[2]` constantly high, `out[3]` never; `busy` stays 0.
- Channel 0, T=4: toggle `ena[0]` 1,0,1,1,0,1 → pulse only after the 4th enabled edge. Then lower `ticks` from 200 to 10 when `cnt`=50 → pulse on the next enabled edge.
- One-shot, T=6: `start` at edge 10 → `busy` 11–16, `out` high only for the cycle after edge 16. A restart `start` at edge 13 moves the pulse to after edge 19.
- `sync` on the same edge as `start` and a due terminal count → no pulse, `busy`=0, all counters 0. Assert `rst` mid-one-shot → `out`=0 and `busy`=0 after the next edge.
- With `MULTI_PULSE_GEN_PHASE_EN`, T=8, phase={0,2,4,7} at `sync` → first pulses after 8, 6, 4 and 1 enabled edges respectively.
- T=255 (max), N=8 → pulse period exactly 255 cycles over 3 periods, with no counter wrap.

Source files
------------

// File: rtl/multi_pulse_generator_if.sv
// multi_pulse_generator_if: control/strobe bundle for multi_pulse_generator.
// Optional MULTI_PULSE_GEN_PHASE_EN adds the per-channel sync phase bus.
interface multi_pulse_generator_if #(
    parameter int N        = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   ena;
    logic [CHANNELS*N-1:0] ticks;
    logic [CHANNELS-1:0]   mode;
    logic [CHANNELS-1:0]   start;
    logic                  sync;
`ifdef MULTI_PULSE_GEN_PHASE_EN
    logic [CHANNELS*N-1:0] phase;
`endif
    logic [CHANNELS-1:0]   out;
    logic [CHANNELS-1:0]   busy;

    modport master (
        output ena, ticks, mode, start, sync,
`ifdef MULTI_PULSE_GEN_PHASE_EN
        output phase,
`endif
        input  out, busy
    );

    modport slave (
        input  ena, ticks, mode, start, sync,
`ifdef MULTI_PULSE_GEN_PHASE_EN
        input  phase,
`endif
        output out, busy
    );
endinterface

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: CHANNELS independent periodic / one-shot strobe
// generators sharing a global phase-align (sync).
// Optional feature macro MULTI_PULSE_GEN_PHASE_EN: sync loads a per-channel
// phase value into each counter instead of 0.

// One channel: counter, strobe, one-shot busy flag and registered mode.
module multi_pulse_generator_lane #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    input  logic         mode,
    input  logic         start,
    input  logic         sync,
    input  logic [N-1:0] sync_val,
    output logic         out,
    output logic         busy
);
    logic [N-1:0] cnt, cnt_d, t_m1;
    logic         mode_q, mode_q_d, out_d, busy_d;
    logic         active, terminal;

    // ticks==0 is caught before counting, so the wrapped t_m1 is never used
    assign t_m1     = ticks - N'(1);
    // >= rather than == so a lowered period fires at once instead of wrapping
    assign terminal = cnt >= t_m1;
    assign active   = !mode_q || busy;

    // Next-state: sync > mode change > inert period > start > count
    always_comb begin
        cnt_d    = cnt;
        mode_q_d = mode_q;
        out_d    = 1'b0;
        busy_d   = busy;
        if (sync) begin
            cnt_d  = sync_val;
            busy_d = 1'b0;
        end else if (mode != mode_q) begin
            cnt_d    = '0;
            busy_d   = 1'b0;
            mode_q_d = mode;
        end else if (ticks == '0) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (mode_q && start) begin
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (active && ena) begin
            if (terminal) begin
                cnt_d  = '0;
                out_d  = 1'b1;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt + N'(1);
            end
        end
    end

    // State registers; reset samples the current mode so no spurious mode change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
            mode_q <= mode;
        end else begin
            cnt    <= cnt_d;
            out    <= out_d;
            busy   <= busy_d;
            mode_q <= mode_q_d;
        end
    end
endmodule

// Top: one lane per channel, slicing the packed period/phase buses.
module multi_pulse_generator #(
    parameter int N        = 8,
    parameter int CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_pulse_generator_if.slave  bus
);
    logic [CHANNELS-1:0] out_w, busy_w;

    assign bus.out  = out_w;
    assign bus.busy = busy_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [N-1:0] sync_val;
`ifdef MULTI_PULSE_GEN_PHASE_EN
        assign sync_val = bus.phase[i*N +: N];
`else
        assign sync_val = '0;
`endif
        multi_pulse_generator_lane #(.N(N)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .ena      (bus.ena[i]),
            .ticks    (bus.ticks[i*N +: N]),
            .mode     (bus.mode[i]),
            .start    (bus.start[i]),
            .sync     (bus.sync),
            .sync_val (sync_val),
            .out      (out_w[i]),
            .busy     (busy_w[i])
        );
    end
endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: directed checks of periodic, one-shot, sync,
// reset and max-period behaviour (N=8, CHANNELS=4).
module tb_multi_pulse_generator;
    localparam int N  = 8;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    multi_pulse_generator_if #(.N(N), .CHANNELS(CH)) bif ();

    multi_pulse_generator #(.N(N), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // advance one edge; outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bif.start = '0;
        bif.sync  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bif.ena = '1; bif.mode = '0; bif.ticks = {8'd0, 8'd1, 8'd5, 8'd3};
        bif.start = '0; bif.sync = 1'b0;
`ifdef MULTI_PULSE_GEN_PHASE_EN
        bif.phase = '0;
`endif
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bif.out !== 4'b0000) begin
            n_err++; $display("FAIL reset_out got %b want 0000", bif.out);
        end
        n_cmp++;
        if (bif.busy !== 4'b0000) begin
            n_err++; $display("FAIL reset_busy got %b want 0000", bif.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_periodic();
        logic [3:0] exp;
        bif.ena = '1; bif.mode = '0; bif.ticks = {8'd0, 8'd1, 8'd5, 8'd3};
        apply_reset();
        for (int e = 1; e <= 15; e++) begin
            tick();
            exp = {1'b0, 1'b1, (e % 5 == 0), (e % 3 == 0)};
            n_cmp++;
            if (bif.out !== exp) begin
                n_err++; $display("FAIL periodic_out edge %0d got %b want %b", e, bif.out, exp);
            end
            n_cmp++;
            if (bif.busy !== 4'b0000) begin
                n_err++; $display("FAIL periodic_busy edge %0d got %b want 0000", e, bif.busy);
            end
        end
    endtask

    task automatic test_ena_toggle();
        logic [5:0] pat;
        pat = 6'b101101;              // ena sequence 1,0,1,1,0,1 (bit 0 first)
        bif.mode = '0; bif.ticks = {8'd0, 8'd0, 8'd0, 8'd4}; bif.ena = '0;
        apply_reset();
        for (int e = 0; e < 6; e++) begin
            bif.ena[0] = pat[e];
            tick();
            n_cmp++;
            if (bif.out[0] !== (e == 5)) begin
                n_err++; $display("FAIL ena_toggle edge %0d got %b want %b", e + 1, bif.out[0], (e == 5));
            end
        end
        // lower the period mid-count
        bif.ticks[7:0] = 8'd200; bif.ena[0] = 1'b1;
        apply_reset();
        for (int e = 1; e <= 50; e++) tick();
        n_cmp++;
        if (bif.out[0] !== 1'b0) begin
            n_err++; $display("FAIL ticks_lower_pre got %b want 0", bif.out[0]);
        end
        bif.ticks[7:0] = 8'd10;
        tick();
        n_cmp++;
        if (bif.out[0] !== 1'b1) begin
            n_err++; $display("FAIL ticks_lower_fire got %b want 1", bif.out[0]);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_cmp++;
            if (bif.out[0] !== (e == 10)) begin
                n_err++; $display("FAIL ticks_lower_next edge %0d got %b want %b", e, bif.out[0], (e == 10));
            end
        end
    endtask

    // one-shot T=6, start at edge 10, optional restart at edge rs (0 = none)
    task automatic run_oneshot(input int rs, input int last_busy, input int pulse_e);
        bif.mode = 4'b0001; bif.ticks = {8'd0, 8'd0, 8'd0, 8'd6}; bif.ena = '1;
        apply_reset();
        for (int e = 1; e <= 25; e++) begin
            bif.start[0] = (e == 10) || (e == rs);
            tick();
            n_cmp++;
            if (bif.busy[0] !== (e >= 10 && e <= last_busy)) begin
                n_err++; $display("FAIL oneshot_busy rs=%0d edge %0d got %b", rs, e, bif.busy[0]);
            end
            n_cmp++;
            if (bif.out[0] !== (e == pulse_e)) begin
                n_err++; $display("FAIL oneshot_out rs=%0d edge %0d got %b want %b", rs, e, bif.out[0], (e == pulse_e));
            end
        end
        bif.start = '0;
    endtask

    task automatic test_oneshot();
        run_oneshot(0, 15, 16);
        run_oneshot(13, 18, 19);
    endtask

    task automatic test_sync();
        // ch0 periodic T=3, ch1 one-shot T=5
        bif.mode = 4'b0010; bif.ticks = {8'd0, 8'd0, 8'd5, 8'd3}; bif.ena = '1;
        apply_reset();
        bif.start[1] = 1'b1;
        tick();                       // edge 1: ch1 armed
        bif.start[1] = 1'b0;
        n_cmp++;
        if (bif.busy[1] !== 1'b1) begin
            n_err++; $display("FAIL sync_pre_busy got %b want 1", bif.busy[1]);
        end
        tick();                       // edge 2: ch0 cnt=2, terminal due next
        bif.sync = 1'b1; bif.start[1] = 1'b1;
        tick();                       // edge 3: sync wins
        bif.sync = 1'b0; bif.start[1] = 1'b0;
        n_cmp++;
        if (bif.out !== 4'b0000) begin
            n_err++; $display("FAIL sync_out got %b want 0000", bif.out);
        end
        n_cmp++;
        if (bif.busy !== 4'b0000) begin
            n_err++; $display("FAIL sync_busy got %b want 0000", bif.busy);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_cmp++;
            if (bif.out !== {3'b000, (e % 3 == 0)} || bif.busy !== 4'b0000) begin
                n_err++; $display("FAIL sync_after edge %0d got out=%b busy=%b", e, bif.out, bif.busy);
            end
        end
        // reset while a one-shot pulse is due
        bif.mode = 4'b0001; bif.ticks = {8'd0, 8'd0, 8'd0, 8'd3};
        apply_reset();
        bif.start[0] = 1'b1;
        tick();
        bif.start[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bif.out[0] !== 1'b0 || bif.busy[0] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_oneshot got out=%b busy=%b want 0 0", bif.out[0], bif.busy[0]);
        end
        tick();
        n_cmp++;
        if (bif.out[0] !== 1'b0 || bif.busy[0] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after got out=%b busy=%b want 0 0", bif.out[0], bif.busy[0]);
        end
    endtask

`ifdef MULTI_PULSE_GEN_PHASE_EN
    task automatic test_phase();
        int first [4];
        first = '{8, 6, 4, 1};
        bif.mode = '0; bif.ticks = {4{8'd8}}; bif.ena = '1;
        bif.phase = {8'd7, 8'd4, 8'd2, 8'd0};
        apply_reset();
        bif.sync = 1'b1;
        tick();
        bif.sync = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (bif.out[c] !== (e == first[c])) begin
                    n_err++; $display("FAIL phase ch%0d edge %0d got %b want %b", c, e, bif.out[c], (e == first[c]));
                end
            end
        end
        bif.phase = '0;
    endtask
`endif

    task automatic test_max_period();
        bif.mode = '0; bif.ticks = {8'd0, 8'd0, 8'd0, 8'd255}; bif.ena = '1;
        apply_reset();
        for (int e = 1; e <= 765; e++) begin
            tick();
            n_cmp++;
            if (bif.out[0] !== (e % 255 == 0)) begin
                n_err++; $display("FAIL max_period edge %0d got %b want %b", e, bif.out[0], (e % 255 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_ena_toggle();
        test_oneshot();
        test_sync();
`ifdef MULTI_PULSE_GEN_PHASE_EN
        test_phase();
`endif
        test_max_period();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
